// File: rtl/fifo_rd_drain.sv
// Read-domain drain engine: pops words from the async FIFO read port and
// forwards them in order through a 2-entry buffer to a valid/ready consumer.
module fifo_rd_drain #(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             power_en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             start,
  input  logic [CNTW-1:0]  len,
  input  logic             stop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  popped
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNTW-1:0]  len_q;
  logic [CNTW-1:0]  popped_nxt;
  logic [1:0]       occ;
  logic [DSIZE-1:0] ent0;
  logic [DSIZE-1:0] ent1;
  logic             room;
  logic             under_len;
  logic             pop_out;

  assign room       = (occ != 2'd2);
  assign under_len  = (len_q == '0) | (popped < len_q);
  assign m_valid    = (occ != 2'd0);
  assign m_data     = ent0;
  assign pop_out    = m_valid & m_ready;
  assign popped_nxt = popped + CNTW'(rinc);

  always_ff @(posedge rclk) begin
    if (rrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (stop || (len_q != '0 && popped_nxt == len_q)) state_nxt = FLUSH;
      FLUSH: if (occ == 2'd0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rinc is purely combinational from the FIFO flags so empty/power act in-cycle
  always_comb begin
    rinc = 1'b0;
    busy = (state != IDLE);
    done = (state == DONE);
    if (state == RUN)
      rinc = power_en & ~rempty & ~stop & room & under_len;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      len_q  <= '0;
      popped <= '0;
      occ    <= 2'd0;
    end else begin
      if (state == IDLE && start) begin
        len_q  <= len;
        popped <= '0;
      end else if (rinc) begin
        popped <= popped_nxt;
      end
      case ({rinc, pop_out})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // ent0 is the head; a push with a simultaneous pop only happens at occ==1
  always_ff @(posedge rclk) begin
    if (rrst) begin
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      if (rinc && (occ == 2'd0 || (occ == 2'd1 && pop_out))) ent0 <= rdata;
      else if (pop_out)                                      ent0 <= ent1;
      if (rinc && occ == 2'd1 && !pop_out) ent1 <= rdata;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain with a behavioural FIFO read port model.
module tb_fifo_rd_drain;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        power_en;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        start;
  logic [15:0] len;
  logic        stop;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        busy;
  logic        done;
  logic [15:0] popped;

  int tests = 0;
  int fails = 0;

  logic [7:0] fmem [0:63];
  int         wp = 0;
  int         rp = 0;
  logic [7:0] rx [0:255];
  int         rx_n = 0;
  int         rinc_cnt = 0;
  int         done_cnt = 0;

  always #5 rclk = ~rclk;

  assign rempty = (wp == rp);
  assign rdata  = fmem[rp % 64];

  fifo_rd_drain #(.DSIZE(8), .CNTW(16)) dut (
    .rclk(rclk), .rrst(rrst), .power_en(power_en), .rempty(rempty),
    .rdata(rdata), .rinc(rinc), .start(start), .len(len), .stop(stop),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .popped(popped)
  );

  always @(posedge rclk) begin
    if (rinc) begin
      rp       <= rp + 1;
      rinc_cnt <= rinc_cnt + 1;
    end
    if (m_valid && m_ready) begin
      rx[rx_n % 256] <= m_data;
      rx_n           <= rx_n + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic push(input logic [7:0] v);
    fmem[wp % 64] = v;
    wp = wp + 1;
  endtask

  task automatic wait_done(output bit ok);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      tick(1);
      c++;
    end
    ok = (done === 1'b1);
    tick(1);
  endtask

  task automatic start_run(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rrst = 1'b1;
    tick(2);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_m_data got %h exp 00", m_data); end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || rinc !== 1'b0) begin fails++; $display("FAIL reset_ctrl got busy=%b done=%b rinc=%b exp 0 0 0", busy, done, rinc); end
    tests++; if (popped !== 16'd0) begin fails++; $display("FAIL reset_popped got %0d exp 0", popped); end
    rrst = 1'b0;
    tick(1);
  endtask

  task automatic test_bounded;
    int rb, db;
    bit ok;
    rb = rx_n; db = done_cnt;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    m_ready = 1'b1;
    start_run(16'd6);
    for (int i = 0; i < 6; i++) begin
      tests++; if (rinc !== 1'b1) begin fails++; $display("FAIL bounded_rinc cycle %0d got %b exp 1", i, rinc); end
      tick(1);
    end
    tests++; if (rinc !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL bounded_flush got rinc=%b busy=%b exp 0 1", rinc, busy); end
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL bounded_done_timeout got no done exp pulse"); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL bounded_idle got busy=%b done=%b exp 0 0", busy, done); end
    tests++; if (popped !== 16'd6) begin fails++; $display("FAIL bounded_popped got %0d exp 6", popped); end
    tests++; if (done_cnt - db !== 1) begin fails++; $display("FAIL bounded_done_pulses got %0d exp 1", done_cnt - db); end
    tests++; if (rx_n - rb !== 6) begin fails++; $display("FAIL bounded_count got %0d exp 6", rx_n - rb); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (rx[(rb + i) % 256] !== 8'hA0 + 8'(i)) begin fails++; $display("FAIL bounded_data[%0d] got %h exp %h", i, rx[(rb + i) % 256], 8'hA0 + 8'(i)); end
    end
  endtask

  task automatic test_backpressure;
    int rb, ib;
    bit ok;
    rb = rx_n; ib = rinc_cnt;
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    m_ready = 1'b0;
    start_run(16'd4);
    tick(10);
    tests++; if (rinc_cnt - ib !== 2) begin fails++; $display("FAIL bp_pops got %0d exp 2", rinc_cnt - ib); end
    tests++; if (m_valid !== 1'b1 || m_data !== 8'hB0) begin fails++; $display("FAIL bp_head got v=%b d=%h exp 1 b0", m_valid, m_data); end
    tests++; if (rinc !== 1'b0 || popped !== 16'd2) begin fails++; $display("FAIL bp_hold got rinc=%b popped=%0d exp 0 2", rinc, popped); end
    m_ready = 1'b1;
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_done_timeout got no done exp pulse"); end
    tests++; if (rx_n - rb !== 4) begin fails++; $display("FAIL bp_count got %0d exp 4", rx_n - rb); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (rx[(rb + i) % 256] !== 8'hB0 + 8'(i)) begin fails++; $display("FAIL bp_data[%0d] got %h exp %h", i, rx[(rb + i) % 256], 8'hB0 + 8'(i)); end
    end
  endtask

  task automatic test_power;
    int rb;
    bit ok;
    rb = rx_n;
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    m_ready = 1'b1;
    start_run(16'd8);
    tick(2);
    power_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL pwr_rinc cycle %0d got %b exp 0", i, rinc); end
      tick(1);
    end
    tests++; if (popped !== 16'd2 || busy !== 1'b1) begin fails++; $display("FAIL pwr_frozen got popped=%0d busy=%b exp 2 1", popped, busy); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL pwr_drained got m_valid=%b exp 0", m_valid); end
    power_en = 1'b1;
    wait_done(ok);
    tests++; if (!ok || popped !== 16'd8) begin fails++; $display("FAIL pwr_end got done=%b popped=%0d exp 1 8", ok, popped); end
    tests++; if (rx_n - rb !== 8) begin fails++; $display("FAIL pwr_count got %0d exp 8", rx_n - rb); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (rx[(rb + i) % 256] !== 8'hC0 + 8'(i)) begin fails++; $display("FAIL pwr_data[%0d] got %h exp %h", i, rx[(rb + i) % 256], 8'hC0 + 8'(i)); end
    end
  endtask

  task automatic test_unbounded;
    int rb, ib;
    bit ok;
    rb = rx_n; ib = rinc_cnt;
    m_ready = 1'b1;
    start_run(16'd0);
    for (int i = 0; i < 8; i++) begin
      tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL unb_empty_rinc cycle %0d got %b exp 0", i, rinc); end
      tick(1);
    end
    for (int i = 0; i < 3; i++) push(8'hD0 + 8'(i));
    tick(5);
    tests++; if (rinc_cnt - ib !== 3 || busy !== 1'b1) begin fails++; $display("FAIL unb_pops got %0d busy=%b exp 3 1", rinc_cnt - ib, busy); end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_done(ok);
    tests++; if (!ok || popped !== 16'd3) begin fails++; $display("FAIL unb_end got done=%b popped=%0d exp 1 3", ok, popped); end
    tests++; if (rx_n - rb !== 3) begin fails++; $display("FAIL unb_count got %0d exp 3", rx_n - rb); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (rx[(rb + i) % 256] !== 8'hD0 + 8'(i)) begin fails++; $display("FAIL unb_data[%0d] got %h exp %h", i, rx[(rb + i) % 256], 8'hD0 + 8'(i)); end
    end
  endtask

  task automatic test_reset_mid;
    int rb;
    bit ok;
    for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
    m_ready = 1'b0;
    start_run(16'd4);
    tick(3);
    tests++; if (m_valid !== 1'b1 || popped !== 16'd2) begin fails++; $display("FAIL rstmid_pre got v=%b popped=%0d exp 1 2", m_valid, popped); end
    rrst = 1'b1;
    tick(1);
    tests++; if (m_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_post got v=%b busy=%b exp 0 0", m_valid, busy); end
    tests++; if (popped !== 16'd0 || rinc !== 1'b0) begin fails++; $display("FAIL rstmid_ctr got popped=%0d rinc=%b exp 0 0", popped, rinc); end
    rrst = 1'b0;
    rb = rx_n;
    m_ready = 1'b1;
    start_run(16'd2);
    wait_done(ok);
    tests++; if (!ok || popped !== 16'd2) begin fails++; $display("FAIL rstmid_rerun got done=%b popped=%0d exp 1 2", ok, popped); end
    tests++; if (rx_n - rb !== 2 || rx[rb % 256] !== 8'hE2 || rx[(rb + 1) % 256] !== 8'hE3) begin fails++; $display("FAIL rstmid_data got n=%0d %h %h exp 2 e2 e3", rx_n - rb, rx[rb % 256], rx[(rb + 1) % 256]); end
  endtask

  task automatic test_start_busy;
    int rb, ib;
    bit ok;
    rb = rx_n; ib = rinc_cnt;
    for (int i = 0; i < 5; i++) push(8'hF0 + 8'(i));
    m_ready = 1'b0;
    start_run(16'd3);
    tick(1);
    start_run(16'd5);
    m_ready = 1'b1;
    wait_done(ok);
    tests++; if (!ok || popped !== 16'd3) begin fails++; $display("FAIL sbusy_len got done=%b popped=%0d exp 1 3", ok, popped); end
    tests++; if (rinc_cnt - ib !== 3 || rx_n - rb !== 3) begin fails++; $display("FAIL sbusy_count got pops=%0d words=%0d exp 3 3", rinc_cnt - ib, rx_n - rb); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (rx[(rb + i) % 256] !== 8'hF0 + 8'(i)) begin fails++; $display("FAIL sbusy_data[%0d] got %h exp %h", i, rx[(rb + i) % 256], 8'hF0 + 8'(i)); end
    end
    wp = rp;
  endtask

  initial begin
    rrst = 1'b1; power_en = 1'b1; start = 1'b0; len = '0; stop = 1'b0; m_ready = 1'b0;
    test_reset;
    test_bounded;
    test_backpressure;
    test_power;
    test_unbounded;
    test_reset_mid;
    test_start_busy;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain engine for the `fifo1` asynchronous FIFO. It lives entirely in the read clock domain. It pops words through the FIFO's `rempty`/`rinc`/`rdata` port and forwards them, in order, to a downstream consumer over a valid/ready stream. A 2-entry output buffer decouples the two sides, so `rinc` never depends combinationally on `m_ready`. Runs are started by a command: either bounded to a word count or unbounded until stopped. Popping is suspended while the FIFO is power-gated.

## Interface
- `DSIZE`, 8, data word width; must match `fifo1`.
- `CNTW`, 16, width of the run length and popped-word counter.

- `rclk`  in  1  read-domain clock; same clock as the FIFO's `rclk`.
- `rrst`  in  1  reset, synchronous, active-high.
- `power_en`  in  1  FIFO power/clock enable; when 0, no pops are issued.
- `rempty`  in  1  FIFO empty flag, registered in the FIFO.
- `rdata`  in  DSIZE  FIFO head word; valid whenever `rempty`=0.
- `rinc`  out  1  FIFO pop strobe.
- `start`  in  1  run request; sampled in IDLE only.
- `len`  in  CNTW  run length, latched on an accepted `start`; 0 means unbounded.
- `stop`  in  1  end the current run; sampled in RUN only.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DSIZE  output word.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at run completion.
- `popped`  out  CNTW  words popped in the current or last run.

## Operation
- **States:** IDLE, RUN, FLUSH, DONE.
- **IDLE:**
  - `start`=1 latches `len`, clears `popped` and moves to RUN.
  - `start` in any other state is ignored.
- **RUN:**
  - `rinc = power_en & ~rempty & ~stop & (occ<2) & (len_q==0 | popped<len_q)`.
  - `rinc` is asserted only in RUN and is 0 in every other state.
  - On each edge with `rinc`=1: `rdata` is written to the buffer tail and `popped` increments.
  - In an unbounded run, `popped` wraps modulo 2^CNTW.
- **RUN → FLUSH:** on `stop`=1, or on a bounded run once `popped`==`len_q` (evaluated with the next value of `popped`).
- **FLUSH:** no pops. Moves to DONE on the first edge where occupancy is 0.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Buffer:**
  - Occupancy `occ` is 0..2. `m_valid = (occ≠0)` and `m_data` = head entry.
  - A word leaves on `m_valid & m_ready`.
  - Simultaneous push and pop leaves `occ` unchanged and preserves order.
  - The output side keeps draining in every state, including while `power_en`=0.
- **`power_en`=0:** only masks `rinc`. State, counters and buffer hold (the buffer still drains to the consumer).
- **`stop`:** masks `rinc` in the same cycle it is asserted.
- **Reset:**
  - Takes effect on the edge where `rrst`=1.
  - After reset: state IDLE, `occ`=0, `m_valid`=0, `m_data`=0, `rinc`=0, `busy`=0, `done`=0, `popped`=0, `len_q`=0.
  - A reset mid-run discards buffered words. Words already popped from the FIFO are lost, and the FIFO pointers are not touched.

## Timing
- **Start:** `start` sampled at edge k → RUN after k. The first `rinc` can be high in the cycle after edge k.
- **Pop latency:** a word popped at edge n appears on `m_data` with `m_valid`=1 immediately after edge n (1 cycle).
- **Throughput:** 1 word/cycle while `m_ready`=1 and the FIFO is non-empty.
- **Backpressure:** with `m_ready`=0, at most 2 words are popped, then `rinc` stays 0 until space frees.
- **Completion, bounded run of len L with `m_ready`=1:**
  - Pops at edges k+1..k+L; FLUSH after edge k+L.
  - `done` is high 2 cycles after the last word leaves.
- **Response to the FIFO:** `rempty` and `power_en` act in the same cycle (`rinc` is combinational from them).

## Test plan
- **Bounded run:** reset, FIFO preloaded A0..A5, `start` with `len`=6, `m_ready`=1 → `rinc` high 6 consecutive cycles; `m_data` A0..A5 in order; `popped`=6; single `done` pulse; `busy` low after.
- **Backpressure:** FIFO holds A0..A3, `start` `len`=4, `m_ready`=0 for 10 cycles → exactly 2 `rinc` pulses, `m_data`=A0 held stable. Then `m_ready`=1 → A0,A1,A2,A3 with no loss or duplication.
- **Power gating:** `power_en`=0 for 5 cycles mid-run (FIFO non-empty) → `rinc`=0 throughout, `popped` frozen. Resumes afterwards with the full sequence intact.
- **Unbounded run with empty gaps:** `len`=0, FIFO empty for 8 cycles, then A0..A2 written → no `rinc` while `rempty`=1, then 3 pops. `stop` → FLUSH, buffer drains, `done` pulses, `popped`=3.
- **Reset mid-run:** `rrst` while `occ`=2 → after the edge `m_valid`=0, `busy`=0, `popped`=0, `rinc`=0. A new `start` works normally.
- **Start while busy:** `start` in RUN with a different `len` → ignored; the run completes with the original length.
